uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter among four byte requesters in the arbiter subsystem. Each requester presents a level request and a byte. The arbiter grants one requester at a time, captures its byte and issues a one-cycle start strobe to the transmitter. It then holds ownership until the transmitter reports completion or a timeout expires. It is the transmit-side counterpart to the receive path and uses the same single-clock, CLKS_PER_BIT-agnostic handshake style.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Grant 1 cycle after a request in IDLE, start strobe 1 cycle later; requests are only sampled in IDLE.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [3:0]  i_Req,
  input  logic [31:0] i_Data,
  input  logic        i_Tx_Done,
  output logic [3:0]  o_Grant,
  output logic [1:0]  o_Owner,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic        o_Busy,
  output logic        o_Timeout
);

  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_CLEANUP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [15:0] r_cnt;
  logic [3:0]  r_grant;
  logic [1:0]  r_owner;
  logic        r_tx_dv;
  logic [7:0]  r_tx_byte;
  logic        r_busy;
  logic        r_timeout;

  logic        w_any;
  logic [1:0]  w_idx;
  logic [1:0]  w_winner;
  logic [7:0]  w_byte;

  // Descending scan so the requester closest above the pointer is written last and wins.
  always_comb begin
    w_any    = |i_Req;
    w_idx    = 2'd0;
    w_winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (i_Req[w_idx]) begin
        w_winner = w_idx;
      end
    end
    w_byte = i_Data[{w_winner, 3'b000} +: 8];
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= 16'd0;
      r_grant   <= 4'd0;
      r_owner   <= 2'd0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_grant   <= 4'd0;
      r_tx_dv   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_tx_byte <= w_byte;
            r_owner   <= w_winner;
            r_grant   <= 4'(4'b0001 << w_winner);
            r_ptr     <= w_winner + 2'd1;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_tx_dv <= 1'b1;
          r_cnt   <= 16'd0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Completion takes precedence over a timeout landing on the same edge.
          if (i_Tx_Done) begin
            r_state <= S_CLEANUP;
          end else if (r_cnt == LP_LIMIT) begin
            r_timeout <= 1'b1;
            r_state   <= S_CLEANUP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CLEANUP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Grant   = r_grant;
  assign o_Owner   = r_owner;
  assign o_Tx_DV   = r_tx_dv;
  assign o_Tx_Byte = r_tx_byte;
  assign o_Busy    = r_busy;
  assign o_Timeout = r_timeout;

endmodule
